wb_stage_p: RTL and testbench

Parametrised MEM/WB pipeline register and writeback unit for the pipelined CPU. It registers every datapath value, including the ALU result, so it has no combinational path from the MEM stage to the register file. It supports stall and flush, a valid bit, and a reserved-source guard. It also provides a forwarding tap, a retired-instruction counter and a sticky halt flag. It sits between the MEM stage and the register-file write port and feeds the hazard/forwarding unit.

---
 rtl/wb_stage_p_pkg.sv | 17 +
 rtl/wb_stage_p_if.sv | 44 ++++
 rtl/wb_stage_p_retire_counter.sv | 20 ++
 rtl/wb_stage_p.sv | 96 +++++++++
 tb/tb_wb_stage_p.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/wb_stage_p_pkg.sv
// Shared writeback-stage constants: source-select encoding and default widths.
// Imported by the interface, the stage and the retire counter.
package wb_stage_p_pkg;

  localparam int WB_WORD_W = 16;
  localparam int WB_REG_AW = 2;
  localparam int WB_PC_INC = 1;
  localparam int WB_CNT_W  = 16;

  typedef enum logic [1:0] {
    WB_SRC_ALU = 2'd0,
    WB_SRC_MEM = 2'd1,
    WB_SRC_PC  = 2'd2,
    WB_SRC_RSV = 2'd3
  } wbSrc_t;

endpackage

// File: rtl/wb_stage_p_if.sv
// MEM->WB bundle: stage control, MEM-stage payload, register-file write port,
// forwarding tap and status. The stage takes the slave side.
interface wb_stage_p_if
  import wb_stage_p_pkg::*;
#(
  parameter int WORD_W = WB_WORD_W,
  parameter int REG_AW = WB_REG_AW,
  parameter int CNT_W  = WB_CNT_W
);
  logic              stall;
  logic              flush;
  logic              valid_in;
  logic [WORD_W-1:0] pc_in;
  logic [WORD_W-1:0] alu_out_in;
  logic [WORD_W-1:0] mem_data_in;
  logic [REG_AW-1:0] wr_target_in;
  logic [1:0]        wb_src_in;
  logic              reg_write_in;
  logic              halt_in;

  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [WORD_W-1:0] rf_wdata;
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_addr;
  logic [WORD_W-1:0] fwd_data;
  logic [CNT_W-1:0]  num_inst;
  logic              halted;

  modport slave (
    input  stall, flush, valid_in, pc_in, alu_out_in, mem_data_in,
           wr_target_in, wb_src_in, reg_write_in, halt_in,
    output rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_addr, fwd_data,
           num_inst, halted
  );

  modport master (
    output stall, flush, valid_in, pc_in, alu_out_in, mem_data_in,
           wr_target_in, wb_src_in, reg_write_in, halt_in,
    input  rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_addr, fwd_data,
           num_inst, halted
  );

endinterface

// File: rtl/wb_stage_p_retire_counter.sv
// Wrapping retired-instruction counter; increments by one per enabled edge.
// Asynchronous active-low clear.
module wb_stage_p_retire_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/wb_stage_p.sv
// MEM/WB pipeline register and writeback mux; one cycle from capture to RF write.
// Stall holds the slot and suppresses its write; flush (dominant) inserts a bubble.
module wb_stage_p
  import wb_stage_p_pkg::*;
#(
  parameter int WORD_W = WB_WORD_W,
  parameter int REG_AW = WB_REG_AW,
  parameter int PC_INC = WB_PC_INC,
  parameter int CNT_W  = WB_CNT_W
) (
  input  logic        clk,
  input  logic        reset_n,
  wb_stage_p_if.slave bus
);

  localparam logic [WORD_W-1:0] PC_STEP = WORD_W'(PC_INC);

  logic              validR;
  logic              regWriteR;
  logic              haltR;
  logic              haltedR;
  logic [WORD_W-1:0] pcR;
  logic [WORD_W-1:0] aluR;
  logic [WORD_W-1:0] memR;
  logic [REG_AW-1:0] tgtR;
  wbSrc_t            srcR;

  logic              retire;
  logic              wrEn;
  logic [WORD_W-1:0] wrData;
  logic [CNT_W-1:0]  numInst;

  // A slot retires on any unstalled cycle; flush only affects what is captured next.
  assign retire = validR & ~bus.stall & ~haltedR;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      validR    <= 1'b0;
      regWriteR <= 1'b0;
      haltR     <= 1'b0;
      haltedR   <= 1'b0;
      pcR       <= '0;
      aluR      <= '0;
      memR      <= '0;
      tgtR      <= '0;
      srcR      <= WB_SRC_ALU;
    end else begin
      if (bus.flush) begin
        validR <= 1'b0;
      end else if (!bus.stall) begin
        validR    <= bus.valid_in & ~haltedR;
        regWriteR <= bus.reg_write_in;
        haltR     <= bus.halt_in;
        pcR       <= bus.pc_in;
        aluR      <= bus.alu_out_in;
        memR      <= bus.mem_data_in;
        tgtR      <= bus.wr_target_in;
        srcR      <= wbSrc_t'(bus.wb_src_in);
      end
      if (retire && haltR) begin
        haltedR <= 1'b1;
      end
    end
  end

  always_comb begin
    wrData = '0;
    case (srcR)
      WB_SRC_ALU: wrData = aluR;
      WB_SRC_MEM: wrData = memR;
      WB_SRC_PC:  wrData = pcR + PC_STEP;
      default:    wrData = '0;
    endcase
  end

  assign wrEn = validR & regWriteR & (srcR != WB_SRC_RSV) & ~haltedR & ~bus.stall;

  wb_stage_p_retire_counter #(
    .CNT_W(CNT_W)
  ) u_retire_counter (
    .clk   (clk),
    .clr_n (reset_n),
    .en    (retire),
    .count (numInst)
  );

  assign bus.rf_we     = wrEn;
  assign bus.rf_waddr  = tgtR;
  assign bus.rf_wdata  = wrData;
  assign bus.fwd_valid = wrEn;
  assign bus.fwd_addr  = tgtR;
  assign bus.fwd_data  = wrData;
  assign bus.num_inst  = numInst;
  assign bus.halted    = haltedR;

endmodule

// File: tb/tb_wb_stage_p.sv
// Bench for wb_stage_p (CNT_W=4 so the counter wrap is reachable):
// expected RF writes are queued at issue and popped when rf_we appears.
module tb_wb_stage_p;
  import wb_stage_p_pkg::*;

  typedef struct {
    logic [1:0]  addr;
    logic [15:0] data;
  } wrEnt_t;

  logic   clk;
  logic   reset_n;
  int     checks;
  int     errors;
  int     expCnt;
  wrEnt_t expQ[$];

  wb_stage_p_if #(.WORD_W(16), .REG_AW(2), .CNT_W(4)) bus ();

  wb_stage_p #(
    .WORD_W(16), .REG_AW(2), .PC_INC(1), .CNT_W(4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Presents one instruction for a single capture edge, then returns to bubbles.
  task automatic issue(input logic rw, input logic [1:0] src, input logic [15:0] pc,
                       input logic [15:0] alu, input logic [15:0] mem,
                       input logic [1:0] tgt, input logic hlt, input bit kill);
    wrEnt_t e;
    bus.valid_in     = 1'b1;
    bus.reg_write_in = rw;
    bus.wb_src_in    = src;
    bus.pc_in        = pc;
    bus.alu_out_in   = alu;
    bus.mem_data_in  = mem;
    bus.wr_target_in = tgt;
    bus.halt_in      = hlt;
    if (!kill && rw && src != WB_SRC_RSV && !bus.stall && !bus.flush) begin
      e.addr = tgt;
      case (src)
        WB_SRC_ALU: e.data = alu;
        WB_SRC_MEM: e.data = mem;
        default:    e.data = pc + 16'd1;
      endcase
      expQ.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    bus.halt_in  = 1'b0;
  endtask

  always @(negedge clk) begin
    wrEnt_t e;
    if (reset_n && bus.rf_we) begin
      if (expQ.size() == 0) begin
        chk("we_unexpected", 32'(bus.rf_we), 32'd0);
      end else begin
        e = expQ.pop_front();
        chk("waddr", 32'(bus.rf_waddr), 32'(e.addr));
        chk("wdata", 32'(bus.rf_wdata), 32'(e.data));
        chk("fwd_valid", 32'(bus.fwd_valid), 32'd1);
        chk("fwd_addr", 32'(bus.fwd_addr), 32'(e.addr));
        chk("fwd_data", 32'(bus.fwd_data), 32'(e.data));
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    expCnt = 0;
    reset_n = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.valid_in = 1'b0;
    bus.pc_in = '0;
    bus.alu_out_in = '0;
    bus.mem_data_in = '0;
    bus.wr_target_in = '0;
    bus.wb_src_in = '0;
    bus.reg_write_in = 1'b0;
    bus.halt_in = 1'b0;

    // Reset, then idle
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_we", 32'(bus.rf_we), 32'd0);
      chk("rst_waddr", 32'(bus.rf_waddr), 32'd0);
      chk("rst_wdata", 32'(bus.rf_wdata), 32'd0);
      chk("rst_fwd_valid", 32'(bus.fwd_valid), 32'd0);
      chk("rst_num", 32'(bus.num_inst), 32'd0);
      chk("rst_halted", 32'(bus.halted), 32'd0);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_we", 32'(bus.rf_we), 32'd0);
      chk("idle_num", 32'(bus.num_inst), 32'd0);
      chk("idle_halted", 32'(bus.halted), 32'd0);
    end

    // ALU writeback
    issue(1'b1, WB_SRC_ALU, 16'h0000, 16'h1234, 16'h0000, 2'd2, 1'b0, 1'b0);
    @(negedge clk);
    chk("alu_we", 32'(bus.rf_we), 32'd1);
    chk("alu_num_before", 32'(bus.num_inst), 32'd0);
    @(negedge clk);
    expCnt++;
    chk("alu_num_after", 32'(bus.num_inst), 32'(expCnt));
    chk("alu_bubble_we", 32'(bus.rf_we), 32'd0);

    // MEM source
    issue(1'b1, WB_SRC_MEM, 16'h0000, 16'h7777, 16'hBEEF, 2'd1, 1'b0, 1'b0);
    @(negedge clk);
    chk("mem_wdata", 32'(bus.rf_wdata), 32'h0000BEEF);
    @(negedge clk);
    expCnt++;

    // PC source wraps
    issue(1'b1, WB_SRC_PC, 16'hFFFF, 16'h7777, 16'h1111, 2'd3, 1'b0, 1'b0);
    @(negedge clk);
    chk("pc_wrap_wdata", 32'(bus.rf_wdata), 32'h00000000);
    chk("pc_wrap_we", 32'(bus.rf_we), 32'd1);
    @(negedge clk);
    expCnt++;

    // Reserved source: no write, still counted
    issue(1'b1, WB_SRC_RSV, 16'h0010, 16'h5555, 16'h6666, 2'd1, 1'b0, 1'b0);
    @(negedge clk);
    chk("rsv_we", 32'(bus.rf_we), 32'd0);
    chk("rsv_wdata", 32'(bus.rf_wdata), 32'd0);
    @(negedge clk);
    expCnt++;
    chk("rsv_num", 32'(bus.num_inst), 32'(expCnt));

    // Stall for 3 cycles, then a single write
    issue(1'b1, WB_SRC_ALU, 16'h0000, 16'h00AA, 16'h0000, 2'd1, 1'b0, 1'b0);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_we", 32'(bus.rf_we), 32'd0);
      chk("stall_wdata", 32'(bus.rf_wdata), 32'h000000AA);
      chk("stall_waddr", 32'(bus.rf_waddr), 32'd1);
      chk("stall_num", 32'(bus.num_inst), 32'(expCnt));
      @(posedge clk);
      #1;
    end
    bus.stall = 1'b0;
    @(negedge clk);
    chk("unstall_we", 32'(bus.rf_we), 32'd1);
    @(negedge clk);
    expCnt++;
    chk("unstall_num", 32'(bus.num_inst), 32'(expCnt));
    chk("unstall_once", 32'(bus.rf_we), 32'd0);

    // Flush and stall together on a live slot: dropped, uncounted
    issue(1'b1, WB_SRC_ALU, 16'h0000, 16'h0BAD, 16'h0000, 2'd3, 1'b0, 1'b1);
    bus.flush = 1'b1;
    bus.stall = 1'b1;
    @(negedge clk);
    chk("fs_we", 32'(bus.rf_we), 32'd0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    @(negedge clk);
    chk("fs_bubble_we", 32'(bus.rf_we), 32'd0);
    @(negedge clk);
    chk("fs_num", 32'(bus.num_inst), 32'(expCnt));

    // Retire and flush on the same edge: retire still completes
    issue(1'b1, WB_SRC_ALU, 16'h0000, 16'h4321, 16'h0000, 2'd0, 1'b0, 1'b0);
    bus.flush = 1'b1;
    @(negedge clk);
    chk("rf_we_flush", 32'(bus.rf_we), 32'd1);
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    expCnt++;
    chk("rf_num_flush", 32'(bus.num_inst), 32'(expCnt));

    // ADD, HLT, ADD
    issue(1'b1, WB_SRC_ALU, 16'h0000, 16'h1111, 16'h0000, 2'd0, 1'b0, 1'b0);
    issue(1'b1, WB_SRC_ALU, 16'h0000, 16'h2222, 16'h0000, 2'd3, 1'b1, 1'b0);
    @(negedge clk);
    chk("pre_halt", 32'(bus.halted), 32'd0);
    issue(1'b1, WB_SRC_ALU, 16'h0000, 16'h3333, 16'h0000, 2'd2, 1'b0, 1'b1);
    expCnt += 2;
    @(negedge clk);
    chk("halted", 32'(bus.halted), 32'd1);
    chk("halt_we", 32'(bus.rf_we), 32'd0);
    chk("halt_num", 32'(bus.num_inst), 32'(expCnt));
    issue(1'b1, WB_SRC_ALU, 16'h0000, 16'h4444, 16'h0000, 2'd1, 1'b0, 1'b1);
    @(negedge clk);
    chk("halt_hold", 32'(bus.halted), 32'd1);
    chk("halt_we2", 32'(bus.rf_we), 32'd0);
    @(negedge clk);
    chk("halt_num_frozen", 32'(bus.num_inst), 32'(expCnt));

    // Reset pulse clears halt and counter
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst2_halted", 32'(bus.halted), 32'd0);
    chk("rst2_num", 32'(bus.num_inst), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // 17 retires on a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      issue(1'b1, WB_SRC_ALU, 16'h0000, 16'(16'h0100 + i), 16'h0000, 2'(i), 1'b0, 1'b0);
    end
    @(negedge clk);
    @(negedge clk);
    chk("wrap_num", 32'(bus.num_inst), 32'd1);
    chk("queue_empty", 32'(expQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
